// File: rtl/float_axis_pkg.sv
// Shared types and constants for the floating-point AXI4-Stream issuer and its benches.
package float_axis_pkg;

  localparam int FLOAT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_A = 2'd2,
    WAIT_B = 2'd3
  } issue_state_t;

  // binary32 encodings of small integers
  localparam logic [FLOAT_W-1:0] FP_ONE   = 32'h3F80_0000;
  localparam logic [FLOAT_W-1:0] FP_TWO   = 32'h4000_0000;
  localparam logic [FLOAT_W-1:0] FP_THREE = 32'h4040_0000;
  localparam logic [FLOAT_W-1:0] FP_FOUR  = 32'h4080_0000;
  localparam logic [FLOAT_W-1:0] FP_FIVE  = 32'h40A0_0000;
  localparam logic [FLOAT_W-1:0] FP_SIX   = 32'h40C0_0000;
  localparam logic [FLOAT_W-1:0] FP_SEVEN = 32'h40E0_0000;
  localparam logic [FLOAT_W-1:0] FP_EIGHT = 32'h4100_0000;
  localparam logic [FLOAT_W-1:0] FP_NINE  = 32'h4110_0000;
  localparam logic [FLOAT_W-1:0] FP_TEN   = 32'h4120_0000;

endpackage

// File: rtl/float_axis_fifo.sv
// Result buffer: DEPTH x DATA_W first-word-fall-through FIFO, synchronous active-high reset.
// A push into a full FIFO is only taken when the head is popped in the same cycle.
module float_axis_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              empty,
  output logic              full,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_en;
  logic              rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/float_axis_issuer.sv
// AXI4-Stream initiator/collector wrapping a Vivado floating-point core behind valid/ready.
// Optional sticky overflow flag: define FLOAT_AXIS_OVF_CHK_EN.
//
// state  | meaning
// IDLE   | no pair pending; accepts a new pair when a credit is free
// ISSUE  | A and B both presented to the core
// WAIT_A | B taken, A still presented
// WAIT_B | A taken, B still presented
module float_axis_issuer
  import float_axis_pkg::*;
#(
  parameter int DATA_W = FLOAT_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              s_axis_a_tvalid,
  input  logic              s_axis_a_tready,
  output logic [DATA_W-1:0] s_axis_a_tdata,
  output logic              s_axis_b_tvalid,
  input  logic              s_axis_b_tready,
  output logic [DATA_W-1:0] s_axis_b_tdata,
  input  logic              m_axis_result_tvalid,
  output logic              m_axis_result_tready,
  input  logic [DATA_W-1:0] m_axis_result_tdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef FLOAT_AXIS_OVF_CHK_EN
  ,
  output logic              err_overflow
`endif
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ISSUE  = ISSUE;
  localparam logic [1:0] ST_WAIT_A = WAIT_A;
  localparam logic [1:0] ST_WAIT_B = WAIT_B;

  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]    state;
  logic [CW-1:0] credit;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;

  // Credit covers both in-flight ops and buffered results, so every result has a slot.
  assign in_ready = !reset && (state == ST_IDLE) && (credit < CW'(DEPTH));
  assign accept   = in_valid && in_ready;

  assign s_axis_a_tvalid = (state == ST_ISSUE) || (state == ST_WAIT_A);
  assign s_axis_b_tvalid = (state == ST_ISSUE) || (state == ST_WAIT_B);

  assign m_axis_result_tready = !reset;
  assign push      = m_axis_result_tvalid && m_axis_result_tready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      s_axis_a_tdata <= '0;
      s_axis_b_tdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            s_axis_a_tdata <= in_a;
            s_axis_b_tdata <= in_b;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          case ({s_axis_a_tready, s_axis_b_tready})
            2'b11:   state <= ST_IDLE;
            2'b10:   state <= ST_WAIT_B;
            2'b01:   state <= ST_WAIT_A;
            default: state <= ST_ISSUE;
          endcase
        end
        ST_WAIT_A: if (s_axis_a_tready) state <= ST_IDLE;
        ST_WAIT_B: if (s_axis_b_tready) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

`ifdef FLOAT_AXIS_OVF_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow <= 1'b0;
    end else if (m_axis_result_tvalid && fifo_full && !pop) begin
      err_overflow <= 1'b1;
    end
  end
`endif

  float_axis_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (m_axis_result_tdata),
    .pop       (pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head      (out_data)
  );

endmodule

// File: tb/tb_float_axis_issuer.sv
// Directed bench for float_axis_issuer with a behavioural multiplier core model.
// Covers the overflow flag when FLOAT_AXIS_OVF_CHK_EN is defined.
module tb_float_axis_issuer;
  import float_axis_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        s_axis_a_tvalid;
  logic        s_axis_a_tready;
  logic [31:0] s_axis_a_tdata;
  logic        s_axis_b_tvalid;
  logic        s_axis_b_tready;
  logic [31:0] s_axis_b_tdata;
  logic        m_axis_result_tvalid;
  logic        m_axis_result_tready;
  logic [31:0] m_axis_result_tdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef FLOAT_AXIS_OVF_CHK_EN
  logic        err_overflow;
`endif

  float_axis_issuer #(.DATA_W(32), .DEPTH(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_a                 (in_a),
    .in_b                 (in_b),
    .s_axis_a_tvalid      (s_axis_a_tvalid),
    .s_axis_a_tready      (s_axis_a_tready),
    .s_axis_a_tdata       (s_axis_a_tdata),
    .s_axis_b_tvalid      (s_axis_b_tvalid),
    .s_axis_b_tready      (s_axis_b_tready),
    .s_axis_b_tdata       (s_axis_b_tdata),
    .m_axis_result_tvalid (m_axis_result_tvalid),
    .m_axis_result_tready (m_axis_result_tready),
    .m_axis_result_tdata  (m_axis_result_tdata),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data)
`ifdef FLOAT_AXIS_OVF_CHK_EN
    ,
    .err_overflow         (err_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [2:0] lvl;
  assign lvl = dut.u_fifo.wr_ptr - dut.u_fifo.rd_ptr;

  // Core model: truncating binary32 multiply, exact for the operands used here.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  typedef struct { logic [31:0] d; int due; } res_t;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  res_t        rq[$];
  logic [31:0] got[$];
  int          cyc = 0;
  int          ip_lat = 8;
  logic        ip_a_rdy = 1'b1;
  logic        ip_b_rdy = 1'b1;
  logic        in_rst = 1'b0;

  initial begin
    s_axis_a_tready      = 1'b0;
    s_axis_b_tready      = 1'b0;
    m_axis_result_tvalid = 1'b0;
    m_axis_result_tdata  = '0;
    forever begin
      logic [31:0] ta, tb;
      @(negedge clk);
      #1;
      cyc++;
      // Core is reset alongside the DUT: pending pairs vanish, results vanish once reset ends.
      if (reset) begin
        qa.delete();
        qb.delete();
        in_rst = 1'b1;
      end else if (in_rst) begin
        rq.delete();
        in_rst = 1'b0;
      end
      s_axis_a_tready = ip_a_rdy;
      s_axis_b_tready = ip_b_rdy;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        m_axis_result_tvalid = 1'b1;
        m_axis_result_tdata  = rq[0].d;
      end else begin
        m_axis_result_tvalid = 1'b0;
        m_axis_result_tdata  = '0;
      end
      #1;
      if (!reset) begin
        if (m_axis_result_tvalid && m_axis_result_tready) void'(rq.pop_front());
        if (s_axis_a_tvalid && s_axis_a_tready) qa.push_back(s_axis_a_tdata);
        if (s_axis_b_tvalid && s_axis_b_tready) qb.push_back(s_axis_b_tdata);
        while (qa.size() > 0 && qb.size() > 0) begin
          ta = qa.pop_front();
          tb = qb.pop_front();
          rq.push_back('{d: fmul(ta, tb), due: cyc + ip_lat});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic issue_op(input logic [31:0] a, input logic [31:0] b);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      #2;
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("issue_accept", ok, 1'b1);
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) @(negedge clk);
    check("result_count", got.size(), n);
  endtask

  task automatic wait_level(input int n, input int budget);
    for (int i = 0; i < budget && int'(lvl) != n; i++) @(negedge clk);
    check("fifo_level", lvl, n);
  endtask

  initial begin
    logic seen_ready;
    logic [31:0] exp_t3 [5];
    logic [31:0] exp_t4 [4];
    exp_t3 = '{FP_ONE, FP_TWO, FP_THREE, FP_FOUR, FP_FIVE};
    exp_t4 = '{FP_SIX, FP_SEVEN, FP_EIGHT, FP_NINE};
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_res_tready", m_axis_result_tready, 1'b0);
    check("rst_a_tvalid", s_axis_a_tvalid, 1'b0);
    check("rst_b_tvalid", s_axis_b_tvalid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_credit", dut.credit, 0);
`ifdef FLOAT_AXIS_OVF_CHK_EN
    check("rst_err", err_overflow, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_res_tready", m_axis_result_tready, 1'b1);
    @(negedge clk);

    // 1) 2.0 x 3.0, latency 8
    out_ready = 1'b1;
    ip_lat    = 8;
    got.delete();
    issue_op(FP_TWO, FP_THREE);
    wait_got(1, 40);
    check("t1_data", got[0], 32'h40C0_0000);
    repeat (12) @(negedge clk);
    check("t1_once", got.size(), 1);
    check("t1_credit", dut.credit, 0);

    // 2) A channel stalls three cycles
    got.delete();
    ip_a_rdy = 1'b0;
    issue_op(FP_ONE, FP_TWO);
    #2;
    check("t2_state_issue", dut.state, 32'(ISSUE));
    check("t2_a_data0", s_axis_a_tdata, FP_ONE);
    check("t2_in_ready0", in_ready, 1'b0);
    @(negedge clk);
    #2;
    check("t2_state_wait_a", dut.state, 32'(WAIT_A));
    check("t2_a_tvalid", s_axis_a_tvalid, 1'b1);
    check("t2_b_tvalid", s_axis_b_tvalid, 1'b0);
    check("t2_a_data1", s_axis_a_tdata, FP_ONE);
    @(negedge clk);
    #2;
    check("t2_a_data2", s_axis_a_tdata, FP_ONE);
    check("t2_in_ready2", in_ready, 1'b0);
    @(negedge clk);
    ip_a_rdy = 1'b1;
    #2;
    check("t2_still_wait_a", dut.state, 32'(WAIT_A));
    check("t2_in_ready3", in_ready, 1'b0);
    @(negedge clk);
    #2;
    check("t2_state_idle", dut.state, 32'(IDLE));
    check("t2_in_ready4", in_ready, 1'b1);
    @(negedge clk);
    wait_got(1, 30);
    check("t2_data", got[0], FP_TWO);

    // 3) credit exhaustion with consumer stalled
    got.delete();
    out_ready = 1'b0;
    ip_lat    = 2;
    for (int i = 0; i < 4; i++) issue_op(exp_t3[i], FP_ONE);
    wait_level(4, 20);
    check("t3_credit_full", dut.credit, 4);
    seen_ready = 1'b0;
    in_valid   = 1'b1;
    in_a       = FP_FIVE;
    in_b       = FP_ONE;
    for (int i = 0; i < 8; i++) begin
      #2;
      seen_ready = seen_ready | in_ready;
      @(negedge clk);
    end
    check("t3_blocked", seen_ready, 1'b0);
    out_ready = 1'b1;
    #2;
    check("t3_ready_before_pop", in_ready, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    check("t3_ready_after_pop", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_credit_refill", dut.credit, 4);
    out_ready = 1'b1;
    wait_got(5, 40);
    for (int i = 0; i < 5; i++) check($sformatf("t3_order%0d", i), got[i], exp_t3[i]);

    // 4) full FIFO with push and pop in the same cycle
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue_op(exp_t4[i], FP_ONE);
    wait_level(4, 20);
    rq.push_back('{d: FP_TEN, due: 0});
    out_ready = 1'b1;
    #2;
    check("t4_res_tvalid", m_axis_result_tvalid, 1'b1);
    check("t4_full", dut.fifo_full, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    check("t4_level_kept", lvl, 4);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    #2;
    check("t4_pop_count", got.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t4_order%0d", i), got[i], exp_t4[i]);
    check("t4_head_valid", out_valid, 1'b1);
    check("t4_head_data", out_data, FP_TEN);
    check("t4_credit", dut.credit, 0);
    @(negedge clk);

    // 5) reset clears leftovers and in-flight ops
    got.delete();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    check("t5_leftover_cleared", out_valid, 1'b0);
    @(negedge clk);
    ip_lat = 6;
    issue_op(FP_ONE, FP_ONE);
    issue_op(FP_TWO, FP_ONE);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_credit", dut.credit, 0);
    repeat (7) @(negedge clk);
    #2;
    check("t5_stale_tvalid", m_axis_result_tvalid, 1'b1);
    check("t5_rst_tready", m_axis_result_tready, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (15) @(negedge clk);
    check("t5_no_stale_valid", out_valid, 1'b0);
    check("t5_no_stale_pop", got.size(), 0);
    check("t5_credit_idle", dut.credit, 0);

`ifdef FLOAT_AXIS_OVF_CHK_EN
    // 6) overflow flag
    out_ready = 1'b0;
    ip_lat    = 2;
    for (int i = 0; i < 4; i++) issue_op(exp_t3[i], FP_ONE);
    wait_level(4, 20);
    check("t6_err_clear", err_overflow, 1'b0);
    rq.push_back('{d: FP_TEN, due: 0});
    @(negedge clk);
    #2;
    check("t6_err_set", err_overflow, 1'b1);
    check("t6_level", lvl, 4);
    check("t6_head", out_data, FP_ONE);
    repeat (5) @(negedge clk);
    check("t6_err_sticky", err_overflow, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("t6_err_reset", err_overflow, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
